axis_reduce_lanes: RTL and testbench

//  Parametrised per-lane stream reducer with multi-context support; successor to the single-context 512b sum/checksum.

---
 rtl/axis_reduce_lanes_if.sv | 33 +++
 rtl/axis_reduce_lanes.sv | 127 ++++++++++++
 tb/tb_axis_reduce_lanes.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_reduce_lanes_if.sv
// Stream bundle for axis_reduce_lanes: input beat channel (with mode sideband) and
// single-beat result channel. The slave modport is the reducer's view.
interface axis_reduce_lanes_if #(
  parameter int DATA_W = 512,
  parameter int ID_W   = 6,
  parameter int CNT_W  = 16
);
  logic [1:0]          mode;
  logic [DATA_W-1:0]   inp_data;
  logic                inp_valid;
  logic                inp_ready;
  logic [DATA_W/8-1:0] inp_keep;
  logic [ID_W-1:0]     inp_id;
  logic                inp_last;
  logic [DATA_W-1:0]   out;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W/8-1:0] out_keep;
  logic [ID_W-1:0]     out_id;
  logic                out_last;
  logic [CNT_W-1:0]    out_beats;
  logic                out_ovf;

  modport slave (
    input  mode, inp_data, inp_valid, inp_keep, inp_id, inp_last, out_ready,
    output inp_ready, out, out_valid, out_keep, out_id, out_last, out_beats, out_ovf
  );

  modport master (
    output mode, inp_data, inp_valid, inp_keep, inp_id, inp_last, out_ready,
    input  inp_ready, out, out_valid, out_keep, out_id, out_last, out_beats, out_ovf
  );
endinterface

// File: rtl/axis_reduce_lanes.sv
// Lane-wise packet reducer (SUM / XOR / unsigned MAX) with N_CH independent contexts
// selected by the low bits of inp_id; one registered result beat per packet.
module axis_reduce_lanes #(
  parameter int DATA_W = 512,
  parameter int LANE_W = 32,
  parameter int ID_W   = 6,
  parameter int N_CH   = 4,
  parameter int CNT_W  = 16
) (
  input logic               clock,
  input logic               reset,
  axis_reduce_lanes_if.slave bus
);
  localparam int N_LANES = DATA_W / LANE_W;
  localparam int KEEP_W  = DATA_W / 8;
  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [1:0] MODE_XOR = 2'd1;
  localparam logic [1:0] MODE_MAX = 2'd2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Returns {carry, lane}; carry is only meaningful for SUM (modes 0 and 3).
  function automatic logic [LANE_W:0] lane_op(input logic [1:0] m,
                                               input logic [LANE_W-1:0] a,
                                               input logic [LANE_W-1:0] d);
    case (m)
      MODE_XOR: return {1'b0, a ^ d};
      MODE_MAX: return {1'b0, (a > d) ? a : d};
      default:  return {1'b0, a} + {1'b0, d};
    endcase
  endfunction

  logic [DATA_W-1:0] r_acc  [N_CH];
  logic [CNT_W-1:0]  r_cnt  [N_CH];
  logic              r_ovf  [N_CH];
  logic [1:0]        r_mode [N_CH];

  logic [DATA_W-1:0] r_res_p1;
  logic              r_vld_p1;
  logic [KEEP_W-1:0] r_keep_p1;
  logic [ID_W-1:0]   r_id_p1;
  logic [CNT_W-1:0]  r_beats_p1;
  logic              r_ovf_p1;

  logic [CH_W-1:0]    w_ch;
  logic               w_inp_ready;
  logic               w_accept;
  logic               w_idle;
  logic [1:0]         w_mode;
  logic [DATA_W-1:0]  w_masked;
  logic [DATA_W-1:0]  w_result;
  logic [N_LANES-1:0] w_lane_carry;
  logic               w_carry;
  logic [CNT_W-1:0]   w_cnt_next;

  assign w_ch        = CH_W'(bus.inp_id) & CH_W'(N_CH - 1);
  assign w_inp_ready = reset & (!r_vld_p1 | bus.out_ready);
  assign w_accept    = bus.inp_valid & w_inp_ready;

  // Stage p0: mask, fold the beat into the selected context
  always_comb begin
    w_masked = '0;
    for (int b = 0; b < KEEP_W; b++)
      w_masked[8*b +: 8] = bus.inp_keep[b] ? bus.inp_data[8*b +: 8] : 8'h00;
    w_idle       = (r_cnt[w_ch] == '0);
    w_mode       = w_idle ? bus.mode : r_mode[w_ch];
    w_result     = '0;
    w_lane_carry = '0;
    for (int i = 0; i < N_LANES; i++)
      {w_lane_carry[i], w_result[i*LANE_W +: LANE_W]} =
        lane_op(w_mode, r_acc[w_ch][i*LANE_W +: LANE_W], w_masked[i*LANE_W +: LANE_W]);
    w_carry    = |w_lane_carry;
    w_cnt_next = sat_inc(r_cnt[w_ch]);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int c = 0; c < N_CH; c++) begin
        r_acc[c]  <= '0;
        r_cnt[c]  <= '0;
        r_ovf[c]  <= 1'b0;
        r_mode[c] <= 2'd0;
      end
      r_res_p1   <= '0;
      r_vld_p1   <= 1'b0;
      r_keep_p1  <= '0;
      r_id_p1    <= '0;
      r_beats_p1 <= '0;
      r_ovf_p1   <= 1'b0;
    end else begin
      if (w_accept) begin
        if (bus.inp_last) begin
          r_res_p1     <= w_result;
          r_beats_p1   <= w_cnt_next;
          r_ovf_p1     <= r_ovf[w_ch] | w_carry;
          r_keep_p1    <= bus.inp_keep;
          r_id_p1      <= bus.inp_id;
          r_acc[w_ch]  <= '0;
          r_cnt[w_ch]  <= '0;
          r_ovf[w_ch]  <= 1'b0;
          r_mode[w_ch] <= 2'd0;
        end else begin
          r_acc[w_ch]  <= w_result;
          r_cnt[w_ch]  <= w_cnt_next;
          r_ovf[w_ch]  <= r_ovf[w_ch] | w_carry;
          r_mode[w_ch] <= w_mode;
        end
      end
      // Stage p1: result register; reload in the same edge as a drain avoids a bubble
      if (w_accept && bus.inp_last)
        r_vld_p1 <= 1'b1;
      else if (bus.out_ready)
        r_vld_p1 <= 1'b0;
    end
  end

  assign bus.inp_ready = w_inp_ready;
  assign bus.out       = r_res_p1;
  assign bus.out_valid = r_vld_p1;
  assign bus.out_last  = r_vld_p1;
  assign bus.out_keep  = r_keep_p1;
  assign bus.out_id    = r_id_p1;
  assign bus.out_beats = r_beats_p1;
  assign bus.out_ovf   = r_ovf_p1;
endmodule

// File: tb/tb_axis_reduce_lanes.sv
// Bench for axis_reduce_lanes: directed scenarios plus randomized traffic checked
// against a packet-level lane reduction model.
module tb_axis_reduce_lanes;
  localparam int DW   = 512;
  localparam int LW   = 32;
  localparam int IDW  = 6;
  localparam int NCH  = 4;
  localparam int CW   = 3;
  localparam int KW   = DW / 8;
  localparam int NL   = DW / LW;
  localparam int CMAX = (1 << CW) - 1;
  localparam logic [KW-1:0] KALL = {KW{1'b1}};

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  axis_reduce_lanes_if #(.DATA_W(DW), .ID_W(IDW), .CNT_W(CW)) bus ();

  axis_reduce_lanes #(.DATA_W(DW), .LANE_W(LW), .ID_W(IDW), .N_CH(NCH), .CNT_W(CW)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int          ch;
    logic [DW-1:0] d;
  } beat_t;

  typedef struct {
    logic [DW-1:0]  data;
    logic [KW-1:0]  keep;
    logic [IDW-1:0] id;
    logic [CW-1:0]  beats;
    logic           ovf;
  } exp_t;

  beat_t beat_q[$];
  exp_t  exp_q[$];
  bit    m_busy [NCH];
  logic [1:0] m_mode [NCH];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [DW-1:0] fill_lanes(input logic [LW-1:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*LW +: LW] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    beat_q.delete();
    exp_q.delete();
    for (int c = 0; c < NCH; c++) m_busy[c] = 0;
  endtask

  // Packet-level model: keep the masked beats per channel, reduce them all at the last beat.
  task automatic model_accept(input logic [1:0] md, input logic [DW-1:0] d,
                              input logic [KW-1:0] k, input logic [IDW-1:0] id, input logic last);
    int c;
    int n;
    beat_t b;
    beat_t rest[$];
    exp_t e;
    logic [DW-1:0] dm;
    longint acc [NL];
    longint v;
    longint lim;
    bit ovf;
    lim = longint'(1) << LW;
    c = int'(id) % NCH;
    for (int j = 0; j < KW; j++) dm[8*j +: 8] = k[j] ? d[8*j +: 8] : 8'h00;
    if (!m_busy[c]) begin
      m_busy[c] = 1;
      m_mode[c] = md;
    end
    b.ch = c;
    b.d  = dm;
    beat_q.push_back(b);
    if (last) begin
      for (int i = 0; i < NL; i++) acc[i] = 0;
      ovf = 0;
      n = 0;
      foreach (beat_q[j]) begin
        if (beat_q[j].ch == c) begin
          n++;
          for (int i = 0; i < NL; i++) begin
            v = longint'(beat_q[j].d[i*LW +: LW]);
            case (m_mode[c])
              2'd1: acc[i] = acc[i] ^ v;
              2'd2: if (v > acc[i]) acc[i] = v;
              default: begin
                acc[i] = acc[i] + v;
                if (acc[i] >= lim) begin
                  acc[i] = acc[i] - lim;
                  ovf = 1;
                end
              end
            endcase
          end
        end else begin
          rest.push_back(beat_q[j]);
        end
      end
      beat_q = rest;
      for (int i = 0; i < NL; i++) e.data[i*LW +: LW] = acc[i][LW-1:0];
      e.keep  = k;
      e.id    = id;
      e.beats = (n > CMAX) ? CW'(CMAX) : CW'(n);
      e.ovf   = ovf;
      exp_q.push_back(e);
      m_busy[c] = 0;
    end
  endtask

  // Presents one beat from T+1 after an edge, returns T+1 after the accepting edge.
  task automatic drive(input logic [1:0] md, input logic [DW-1:0] d, input logic [KW-1:0] k,
                       input logic [IDW-1:0] id, input logic last);
    int waited;
    waited = 0;
    bus.mode      = md;
    bus.inp_data  = d;
    bus.inp_keep  = k;
    bus.inp_id    = id;
    bus.inp_last  = last;
    bus.inp_valid = 1'b1;
    #1;
    while (!bus.inp_ready) begin
      @(posedge clock);
      #2;
      waited++;
      if (waited > 50) begin
        $display("FAIL drive_timeout inp_ready stayed 0 for %0d cycles, required 1", waited);
        $fatal(1, "input handshake never completed");
      end
    end
    model_accept(md, d, k, id, last);
    @(posedge clock);
    #1;
    bus.inp_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    bus.inp_valid = 1'b0;
    bus.inp_last  = 1'b0;
    bus.inp_data  = '0;
    bus.inp_keep  = '0;
    bus.inp_id    = '0;
    bus.mode      = 2'd0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out !== '0) $display("FAIL reset_out got=%h want=0", bus.out); else n_pass++;
    n_checks++; if (bus.out_keep !== '0 || bus.out_id !== '0) $display("FAIL reset_keep_id got=%h/%h want=0/0", bus.out_keep, bus.out_id); else n_pass++;
    n_checks++; if (bus.out_beats !== '0 || bus.out_ovf !== 1'b0) $display("FAIL reset_beats_ovf got=%0d/%b want=0/0", bus.out_beats, bus.out_ovf); else n_pass++;
    n_checks++; if (bus.inp_ready !== 1'b0) $display("FAIL reset_inp_ready got=%b want=0", bus.inp_ready); else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++; if (bus.inp_ready !== 1'b1) $display("FAIL reset_release_ready got=%b want=1", bus.inp_ready); else n_pass++;
    @(posedge clock);
    #1;
    model_reset();
  endtask

  task automatic test_sum_basic();
    drive(2'd0, fill_lanes(32'd1), KALL, 6'd1, 1'b0);
    drive(2'd0, fill_lanes(32'd2), KALL, 6'd1, 1'b0);
    drive(2'd0, fill_lanes(32'd3), KALL, 6'd1, 1'b1);
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b1) $display("FAIL sum_basic_valid got=%b/%b want=1/1", bus.out_valid, bus.out_last); else n_pass++;
    n_checks++; if (bus.out !== fill_lanes(32'd6)) $display("FAIL sum_basic_out got=%h want=%h", bus.out, fill_lanes(32'd6)); else n_pass++;
    n_checks++; if (bus.out_beats !== 3'd3 || bus.out_ovf !== 1'b0) $display("FAIL sum_basic_beats_ovf got=%0d/%b want=3/0", bus.out_beats, bus.out_ovf); else n_pass++;
    n_checks++; if (bus.out_id !== 6'd1 || bus.out_keep !== KALL) $display("FAIL sum_basic_id_keep got=%0d/%h want=1/all", bus.out_id, bus.out_keep); else n_pass++;
    @(posedge clock);
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL sum_basic_drain got=%b want=0", bus.out_valid); else n_pass++;
    exp_q.delete();
  endtask

  task automatic test_overflow_xor();
    logic [DW-1:0] d0, d1, e;
    d0 = '0; d0[31:0] = 32'hFFFF_FFFF;
    d1 = '0; d1[31:0] = 32'h0000_0002;
    drive(2'd0, d0, KALL, 6'd1, 1'b0);
    drive(2'd0, d1, KALL, 6'd1, 1'b1);
    e = '0; e[31:0] = 32'h1;
    n_checks++; if (bus.out !== e) $display("FAIL sum_ovf_out got=%h want=%h", bus.out, e); else n_pass++;
    n_checks++; if (bus.out_ovf !== 1'b1) $display("FAIL sum_ovf_flag got=%b want=1", bus.out_ovf); else n_pass++;
    drive(2'd1, d0, KALL, 6'd1, 1'b0);
    drive(2'd1, d1, KALL, 6'd1, 1'b1);
    e = '0; e[31:0] = 32'hFFFF_FFFD;
    n_checks++; if (bus.out !== e) $display("FAIL xor_out got=%h want=%h", bus.out, e); else n_pass++;
    n_checks++; if (bus.out_ovf !== 1'b0) $display("FAIL xor_ovf got=%b want=0", bus.out_ovf); else n_pass++;
    @(posedge clock);
    #1;
    exp_q.delete();
  endtask

  task automatic test_max_keep();
    logic [DW-1:0] d0, d1, e;
    logic [KW-1:0] k1;
    d0 = '0; d0[31:0] = 32'h10; d0[63:32] = 32'h100;
    d1 = '0; d1[31:0] = 32'h80; d1[63:32] = 32'h200;
    k1 = ~KW'(64'hF);
    drive(2'd2, d0, KALL, 6'd2, 1'b0);
    drive(2'd2, d1, k1, 6'd2, 1'b1);
    e = '0; e[31:0] = 32'h10; e[63:32] = 32'h200;
    n_checks++; if (bus.out !== e) $display("FAIL max_keep_out got=%h want=%h", bus.out, e); else n_pass++;
    n_checks++; if (bus.out_keep !== k1 || bus.out_beats !== 3'd2) $display("FAIL max_keep_meta got=%h/%0d want=%h/2", bus.out_keep, bus.out_beats, k1); else n_pass++;
    @(posedge clock);
    #1;
    exp_q.delete();
  endtask

  task automatic test_interleave();
    drive(2'd0, fill_lanes(32'd5),  KALL, 6'd0, 1'b0);
    drive(2'd0, fill_lanes(32'd9),  KALL, 6'd1, 1'b0);
    drive(2'd0, fill_lanes(32'd7),  KALL, 6'd0, 1'b1);
    n_checks++; if (bus.out !== fill_lanes(32'd12) || bus.out_id !== 6'd0) $display("FAIL interleave_id0 got=%h id=%0d want lanes=12 id=0", bus.out, bus.out_id); else n_pass++;
    drive(2'd0, fill_lanes(32'd11), KALL, 6'd1, 1'b1);
    n_checks++; if (bus.out !== fill_lanes(32'd20) || bus.out_id !== 6'd1) $display("FAIL interleave_id1 got=%h id=%0d want lanes=20 id=1", bus.out, bus.out_id); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL interleave_valid got=%b want=1", bus.out_valid); else n_pass++;
    @(posedge clock);
    #1;
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] da, db;
    exp_t ea, eb;
    da = rand_data();
    db = rand_data();
    bus.out_ready = 1'b0;
    drive(2'd0, da, KALL, 6'd0, 1'b1);
    ea = exp_q.pop_front();
    bus.mode = 2'd0; bus.inp_data = db; bus.inp_keep = KALL; bus.inp_id = 6'd1;
    bus.inp_last = 1'b1; bus.inp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (bus.out !== ea.data || bus.out_valid !== 1'b1) $display("FAIL bp_hold_%0d got=%h v=%b want=%h v=1", i, bus.out, bus.out_valid, ea.data); else n_pass++;
      n_checks++; if (bus.inp_ready !== 1'b0) $display("FAIL bp_ready_%0d got=%b want=0", i, bus.inp_ready); else n_pass++;
      @(posedge clock);
      #1;
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.inp_ready !== 1'b1) $display("FAIL bp_release_ready got=%b want=1", bus.inp_ready); else n_pass++;
    model_accept(2'd0, db, KALL, 6'd1, 1'b1);
    eb = exp_q.pop_front();
    @(posedge clock);
    #1;
    bus.inp_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out !== eb.data || bus.out_id !== 6'd1) $display("FAIL bp_next got=%h v=%b id=%0d want=%h v=1 id=1", bus.out, bus.out_valid, bus.out_id, eb.data); else n_pass++;
    n_checks++; if (bus.out_ovf !== eb.ovf) $display("FAIL bp_next_ovf got=%b want=%b", bus.out_ovf, eb.ovf); else n_pass++;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset_midpacket();
    drive(2'd0, fill_lanes(32'd4), KALL, 6'd2, 1'b0);
    drive(2'd0, fill_lanes(32'd4), KALL, 6'd2, 1'b0);
    bus.out_ready = 1'b0;
    drive(2'd0, fill_lanes(32'd9), KALL, 6'd0, 1'b1);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.out !== '0) $display("FAIL midreset_drop got=%b/%h want=0/0", bus.out_valid, bus.out); else n_pass++;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    drive(2'd0, fill_lanes(32'd4), KALL, 6'd2, 1'b0);
    drive(2'd0, fill_lanes(32'd4), KALL, 6'd2, 1'b1);
    n_checks++; if (bus.out !== fill_lanes(32'd8) || bus.out_beats !== 3'd2) $display("FAIL midreset_fresh got=%h beats=%0d want lanes=8 beats=2", bus.out, bus.out_beats); else n_pass++;
    @(posedge clock);
    #1;
    exp_q.delete();
  endtask

  task automatic test_saturation_mode_change();
    for (int i = 0; i < 10; i++) drive(2'd0, fill_lanes(32'd1), KALL, 6'd3, (i == 9));
    n_checks++; if (bus.out !== fill_lanes(32'd10)) $display("FAIL sat_out got=%h want lanes=10", bus.out); else n_pass++;
    n_checks++; if (bus.out_beats !== CW'(CMAX)) $display("FAIL sat_beats got=%0d want=%0d", bus.out_beats, CMAX); else n_pass++;
    drive(2'd1, fill_lanes(32'd3), KALL, 6'd1, 1'b0);
    drive(2'd0, fill_lanes(32'd1), KALL, 6'd1, 1'b1);
    n_checks++; if (bus.out !== fill_lanes(32'd2) || bus.out_ovf !== 1'b0) $display("FAIL mode_change got=%h ovf=%b want lanes=2 ovf=0", bus.out, bus.out_ovf); else n_pass++;
    @(posedge clock);
    #1;
    exp_q.delete();
  endtask

  task automatic test_random();
    exp_t e;
    logic [1:0] md;
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [IDW-1:0] id;
    logic last;
    for (int cyc = 0; cyc < 600; cyc++) begin
      md = 2'($urandom_range(0, 3));
      d  = rand_data();
      k  = ($urandom_range(0, 1) == 0) ? KALL : {$urandom, $urandom};
      id = IDW'($urandom_range(0, 7));
      last = ($urandom_range(0, 2) == 0);
      bus.mode = md; bus.inp_data = d; bus.inp_keep = k; bus.inp_id = id; bus.inp_last = last;
      bus.inp_valid = (cyc < 560) && ($urandom_range(0, 3) != 0);
      bus.out_ready = (cyc >= 560) || ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL rand_unexpected_result got=%h want=no result", bus.out);
        end else begin
          e = exp_q.pop_front();
          if (bus.out !== e.data || bus.out_keep !== e.keep || bus.out_id !== e.id ||
              bus.out_beats !== e.beats || bus.out_ovf !== e.ovf || bus.out_last !== 1'b1)
            $display("FAIL rand_result cyc=%0d got id=%0d beats=%0d ovf=%b data=%h want id=%0d beats=%0d ovf=%b data=%h",
                     cyc, bus.out_id, bus.out_beats, bus.out_ovf, bus.out, e.id, e.beats, e.ovf, e.data);
          else n_pass++;
        end
      end
      if (bus.inp_valid && bus.inp_ready) model_accept(md, d, k, id, last);
      @(posedge clock);
      #1;
    end
    bus.inp_valid = 1'b0;
    n_checks++; if (exp_q.size() != 0) $display("FAIL rand_missing_results got=%0d pending want=0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sum_basic();
    test_overflow_xor();
    test_max_keep();
    test_interleave();
    test_back_to_back();
    test_reset_midpacket();
    test_saturation_mode_change();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
